// File: rtl/alu_driver.sv
// ALU exerciser: steps operands, alternates add/subtract requests and scores the ALU's results.
// Optional macro ALU_DRIVER_HALT_ON_ERR_EN ends a run on its first mismatching result.
module alu_driver #(
    parameter int unsigned A_STEP = 2,
    parameter int unsigned B_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_iter,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic        op_o,
    input  logic [31:0] z_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] NO_ERR = 16'hFFFF;

`ifdef ALU_DRIVER_HALT_ON_ERR_EN
    localparam bit HALT_ON_ERR = 1'b1;
`else
    localparam bit HALT_ON_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_nxt;
    logic [DW-1:0] a_nxt, b_nxt;
    logic          op_nxt, busy_nxt, done_nxt;
    logic [CW-1:0] pass_nxt, err_nxt, fei_nxt;
    logic [CW-1:0] iter_q, iter_nxt;
    logic [CW-1:0] num_q, num_nxt;
    logic [DW-1:0] expect_c;
    logic          match_c;
    logic          more_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == NO_ERR) ? v : v + CW'(1);
    endfunction

    // Reference result for the operation currently presented to the ALU
    always_comb begin
        expect_c = (state_q == S_SUB) ? (a_o - b_o) : (a_o + b_o);
        match_c  = (z_i == expect_c);
        more_c   = ((17'({1'b0, iter_q}) + 17'd1) < 17'({1'b0, num_q}));
    end

    always_comb begin
        state_nxt = state_q;
        a_nxt     = a_o;
        b_nxt     = b_o;
        op_nxt    = op_o;
        pass_nxt  = pass_count;
        err_nxt   = err_count;
        fei_nxt   = first_err_idx;
        iter_nxt  = iter_q;
        num_nxt   = num_q;

        // Score the result on the exit edge of either check state
        if (state_q == S_ADD || state_q == S_SUB) begin
            if (match_c) begin
                pass_nxt = sat_inc(pass_count);
            end else begin
                err_nxt = sat_inc(err_count);
                if (first_err_idx == NO_ERR) begin
                    fei_nxt = iter_q;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pass_nxt = '0;
                    err_nxt  = '0;
                    fei_nxt  = NO_ERR;
                    num_nxt  = num_iter;
                    iter_nxt = '0;
                    if (num_iter != '0) begin
                        state_nxt = S_ADD;
                        a_nxt     = a_o + DW'(A_STEP);
                        b_nxt     = b_o + DW'(B_STEP);
                        op_nxt    = 1'b0;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ADD: begin
                if (HALT_ON_ERR && !match_c) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SUB;
                    op_nxt    = 1'b1;
                end
            end
            S_SUB: begin
                if ((HALT_ON_ERR && !match_c) || !more_c) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ADD;
                    a_nxt     = a_o + DW'(A_STEP);
                    b_nxt     = b_o + DW'(B_STEP);
                    op_nxt    = 1'b0;
                    iter_nxt  = iter_q + CW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == S_ADD) || (state_nxt == S_SUB);
        done_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o           <= '0;
            b_o           <= '0;
            op_o          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass_count    <= '0;
            err_count     <= '0;
            first_err_idx <= NO_ERR;
            iter_q        <= '0;
            num_q         <= '0;
        end else begin
            a_o           <= a_nxt;
            b_o           <= b_nxt;
            op_o          <= op_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            pass_count    <= pass_nxt;
            err_count     <= err_nxt;
            first_err_idx <= fei_nxt;
            iter_q        <= iter_nxt;
            num_q         <= num_nxt;
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Randomized bench for alu_driver: a behavioural ALU drives z_i and a run-level model predicts results.
module tb_alu_driver;

`ifdef ALU_DRIVER_HALT_ON_ERR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_iter;
    logic [31:0] a_o, b_o, z_i;
    logic        op_o, busy, done;
    logic [15:0] pass_count, err_count, first_err_idx;

    logic        start2;
    logic [15:0] num_iter2;
    logic [31:0] a2, b2, z2;
    logic        op2, busy2, done2;
    logic [15:0] pass2, err2, fei2;

    int          alu_mode;
    logic [2:0]  fault_sel;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_a, m_b;

    always #5 clk = ~clk;

    // mode 0: correct ALU, 1: always a-b, 2: flips bit 0 when a[2:0] == sel
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic op, input int mode, input logic [2:0] sel);
        logic [31:0] r;
        r = op ? (a - b) : (a + b);
        if (mode == 1) r = a - b;
        if (mode == 2 && a[2:0] == sel) r = r ^ 32'd1;
        return r;
    endfunction

    assign z_i = alu_f(a_o, b_o, op_o, alu_mode, fault_sel);
    assign z2  = op2 ? (a2 - b2) : (a2 + b2);

    alu_driver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_iter(num_iter),
        .a_o(a_o), .b_o(b_o), .op_o(op_o), .z_i(z_i),
        .busy(busy), .done(done), .pass_count(pass_count),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    alu_driver #(.A_STEP(32'hC000_0000), .B_STEP(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_iter(num_iter2),
        .a_o(a2), .b_o(b2), .op_o(op2), .z_i(z2),
        .busy(busy2), .done(done2), .pass_count(pass2),
        .err_count(err2), .first_err_idx(fei2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a"},    a_o, 32'd0);
        check({tag, "_b"},    b_o, 32'd0);
        check({tag, "_op"},   32'(op_o), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass_count), 32'd0);
        check({tag, "_err"},  32'(err_count), 32'd0);
        check({tag, "_fei"},  32'(first_err_idx), 32'h0000_FFFF);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_a = '0;
        m_b = '0;
    endtask

    // One run: predict the outcome from iteration semantics, then drive it and compare
    task automatic run(input int n, input int mode, input bit poke_start);
        int          e_pass = 0, e_err = 0, e_busy = 0;
        logic [15:0] e_fei = 16'hFFFF;
        bit          halted = 0;
        int          busy_seen = 0;
        bit          got_done = 0;
        logic [31:0] z;

        for (int i = 0; i < n && !halted; i++) begin
            m_a = m_a + 32'd2;
            m_b = m_b + 32'd1;
            e_busy++;
            z = alu_f(m_a, m_b, 1'b0, mode, fault_sel);
            if (z == m_a + m_b) e_pass++;
            else begin
                e_err++;
                if (e_fei == 16'hFFFF) e_fei = 16'(i);
                if (HALT) halted = 1;
            end
            if (!halted) begin
                e_busy++;
                z = alu_f(m_a, m_b, 1'b1, mode, fault_sel);
                if (z == m_a - m_b) e_pass++;
                else begin
                    e_err++;
                    if (e_fei == 16'hFFFF) e_fei = 16'(i);
                    if (HALT) halted = 1;
                end
            end
        end

        alu_mode = mode;
        @(negedge clk);
        start    = 1'b1;
        num_iter = 16'(n);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 300 && !got_done; k++) begin
            @(negedge clk);
            if (poke_start && k == 1) start = 1'b1;
            if (poke_start && k == 2) start = 1'b0;
            if (busy) busy_seen++;
            if (done) got_done = 1;
        end
        start = 1'b0;
        check("done_seen",   32'(got_done), 32'd1);
        check("busy_cycles", 32'(busy_seen), 32'(e_busy));
        check("a_final",     a_o, m_a);
        check("b_final",     b_o, m_b);
        check("pass_count",  32'(pass_count), 32'(e_pass));
        check("err_count",   32'(err_count), 32'(e_err));
        check("first_err",   32'(first_err_idx), 32'(e_fei));
        @(negedge clk);
        check("done_pulse",  32'(done), 32'd0);
        check("idle_busy",   32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        num_iter  = '0;
        start2    = 1'b0;
        num_iter2 = '0;
        alu_mode  = 0;
        fault_sel = '0;
        m_a       = '0;
        m_b       = '0;
        #12;
        check_reset_values("reset");
        do_reset();

        // Single iteration with a correct ALU
        run(1, 0, 0);
        check("one_iter_a", a_o, 32'd2);
        check("one_iter_b", b_o, 32'd1);

        do_reset();
        run(4, 0, 1);
        check("four_iter_pass", 32'(pass_count), 32'd8);

        // Operands persist; zero-iteration run leaves them alone and clears counters
        run(2, 0, 0);
        run(0, 0, 0);

        do_reset();
        run(3, 1, 0);

        for (int r = 0; r < 8; r++) begin
            fault_sel = 3'($urandom);
            run(int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset in the SUB cycle of the second iteration
        do_reset();
        alu_mode = 0;
        @(negedge clk);
        start    = 1'b1;
        num_iter = 16'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("pre_reset_op", 32'(op_o), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_values("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        m_a = '0;
        m_b = '0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("no_done_after_reset", 32'(seen), 32'd0);
        run(0, 0, 0);

        // Wrapping operands on a second instance with large steps
        @(negedge clk);
        start2    = 1'b1;
        num_iter2 = 16'd3;
        @(posedge clk);
        #1 start2 = 1'b0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (done2) seen = 1;
        end
        check("wrap_done", 32'(seen), 32'd1);
        check("wrap_a",    a2, 32'h4000_0000);
        check("wrap_b",    b2, 32'hFFFF_FFFD);
        check("wrap_pass", 32'(pass2), 32'd6);
        check("wrap_err",  32'(err2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
